// File: rtl/cke_gen_pkg.sv
// ---------------------------------------------------------------------------
// cke_gen_pkg
//   Shared definitions for the multi-channel clock-enable generator.
//   - CFG_W       : default width of period/high/count fields
//   - DEF_PERIOD  : period (clk cycles) every channel starts with after reset
//   - DEF_HIGH    : high time (clk cycles) every channel starts with after reset
//   - cfg_t       : one channel's {period, high} programming word
//   - last_count  : final count value of a period, with period 0 treated as 1
// ---------------------------------------------------------------------------
package cke_gen_pkg;

  localparam int CFG_W      = 26;
  localparam int DEF_PERIOD = 50_000_000;
  localparam int DEF_HIGH   = 25_000_000;

  typedef struct packed {
    logic [CFG_W-1:0] period;
    logic [CFG_W-1:0] high;
  } cfg_t;

  // Last count value before wrapping. A programmed period of 0 is clamped to
  // 1, so the channel then wraps every cycle instead of underflowing.
  // Operates on 32 bits, so field widths up to 32 are supported.
  function automatic logic [31:0] last_count(input logic [31:0] period);
    return (period == 32'd0) ? 32'd0 : period - 32'd1;
  endfunction

endpackage

// File: rtl/cke_chan.sv
// ---------------------------------------------------------------------------
// cke_chan
//   One channel of the clock-enable generator: a free-running period counter
//   with a programmable high time and a one-deep pending-update slot. Pending
//   values are applied only at a period boundary (wrap), while frozen, or on
//   sync, so the output never shows a truncated or stretched pulse.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_       in   synchronous active-low reset
//   i_ena      in   global enable; low freezes the counter and gates outputs
//   i_sync     in   restart the counter at 0 on the next edge
//   i_wr       in   load i_period/i_high into the pending slot
//   i_period   in   W  new period
//   i_high     in   W  new high time
//   o_pend     out  pending slot occupied (channel not ready for config)
//   o_cke      out  clock enable: count < high
//   o_tick     out  period-start pulse: count == 0
// ---------------------------------------------------------------------------
module cke_chan
  import cke_gen_pkg::last_count;
#(
  parameter int W          = 26,
  parameter int DEF_PERIOD = 50_000_000,
  parameter int DEF_HIGH   = 25_000_000
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         i_ena,
  input  logic         i_sync,
  input  logic         i_wr,
  input  logic [W-1:0] i_period,
  input  logic [W-1:0] i_high,
  output logic         o_pend,
  output logic         o_cke,
  output logic         o_tick
);

  typedef struct packed {
    logic [W-1:0] period;
    logic [W-1:0] high;
  } chan_cfg_t;

  chan_cfg_t    r_cfg;
  chan_cfg_t    r_pend_cfg;
  logic         r_pend;
  logic [W-1:0] r_count;

  logic [W-1:0] w_last;
  logic         w_wrap;
  logic         w_apply;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally), so no latch can be inferred.
  always_comb begin
    w_last  = W'(last_count(32'(r_cfg.period)));
    w_wrap  = (r_count == w_last);
    // Apply at the wrap edge, immediately while frozen, or on sync. With
    // i_ena low the counter is parked, so there is no pulse to cut short.
    w_apply = r_pend && (i_sync || !i_ena || w_wrap);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_count      <= '0;
      r_cfg.period <= W'(DEF_PERIOD);
      r_cfg.high   <= W'(DEF_HIGH);
      r_pend       <= 1'b0;
    end else begin
      if (i_sync || w_apply) begin
        r_count <= '0;
      end else if (i_ena) begin
        r_count <= w_wrap ? '0 : r_count + W'(1);
      end

      // i_wr is only raised while r_pend is clear, so it never collides
      // with an apply in the same cycle.
      if (w_apply) begin
        r_cfg  <= r_pend_cfg;
        r_pend <= 1'b0;
      end else if (i_wr) begin
        r_pend <= 1'b1;
      end
    end
  end

  // NOTE: the pending payload is deliberately not reset; it is only ever
  // consumed while r_pend is set, and r_pend itself is reset.
  always_ff @(posedge clk) begin
    if (i_wr) begin
      r_pend_cfg <= '{period: i_period, high: i_high};
    end
  end

  // Outputs come straight from registered state, gated so nothing toggles
  // while held in reset or disabled.
  assign o_pend = r_pend;
  assign o_cke  = rst_ && i_ena && (r_count < r_cfg.high);
  assign o_tick = rst_ && i_ena && (r_count == '0);

endmodule

// File: rtl/cke_gen_multi.sv
// ---------------------------------------------------------------------------
// cke_gen_multi
//   Multi-channel runtime-programmable clock-enable generator. Each channel
//   produces a clock enable with its own period and high time plus a
//   one-cycle period-start tick. Channels are reprogrammed through a
//   valid/ready port; updates land at period boundaries.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_        in   synchronous active-low reset
//   ena         in   global enable; low freezes counters, forces cke/tick 0
//   sync        in   one-cycle pulse: restart all channels at count 0
//   cfg_valid   in   config request valid
//   cfg_ready   out  config request accepted when cfg_valid && cfg_ready
//   cfg_ch      in   CHW  target channel; indices >= CH are accepted and dropped
//   cfg_period  in   W    new period in cycles (0 behaves as 1)
//   cfg_high    in   W    new high time in cycles
//   cke         out  CH   per-channel clock enable
//   tick        out  CH   per-channel period-start pulse
// ---------------------------------------------------------------------------
module cke_gen_multi
  import cke_gen_pkg::CFG_W;
#(
  parameter  int CH         = 4,
  parameter  int W          = CFG_W,
  parameter  int DEF_PERIOD = cke_gen_pkg::DEF_PERIOD,
  parameter  int DEF_HIGH   = cke_gen_pkg::DEF_HIGH,
  localparam int CHW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           ena,
  input  logic           sync,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_period,
  input  logic [W-1:0]   cfg_high,
  output logic [CH-1:0]  cke,
  output logic [CH-1:0]  tick
);

  logic [CH-1:0] w_sel;
  logic [CH-1:0] w_pend;
  logic [CH-1:0] w_wr;
  logic          w_ready;

  // One-hot channel decode. An out-of-range index selects nothing, so it
  // sees no pending channel (ready) and its write strobe goes nowhere.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < CH; i++) begin
      w_sel[i] = (cfg_ch == CHW'(i));
    end
  end

  assign w_ready   = rst_ && ((w_sel & w_pend) == '0);
  assign w_wr      = {CH{cfg_valid && w_ready}} & w_sel;
  assign cfg_ready = w_ready;

  for (genvar g = 0; g < CH; g++) begin : g_chan
    cke_chan #(
      .W          (W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   (DEF_HIGH)
    ) u_chan (
      .clk      (clk),
      .rst_     (rst_),
      .i_ena    (ena),
      .i_sync   (sync),
      .i_wr     (w_wr[g]),
      .i_period (cfg_period),
      .i_high   (cfg_high),
      .o_pend   (w_pend[g]),
      .o_cke    (cke[g]),
      .o_tick   (tick[g])
    );
  end

endmodule

// File: tb/tb_cke_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_cke_gen_multi
//   Directed scoreboard bench. The stimulus process drives one cycle at a
//   time and queues the hand-derived cke/tick/cfg_ready expected for that
//   cycle; a monitor pops and compares on the falling edge. Cycle k=0 is the
//   first cycle after reset release; DEF_PERIOD=10, DEF_HIGH=5.
// ---------------------------------------------------------------------------
module tb_cke_gen_multi;
  import cke_gen_pkg::*;

  localparam int CH  = 4;
  localparam int W   = 26;
  localparam int CHW = 2;

  // Phase with sync + pending, k=70..81, bit i = channel i.
  localparam logic [3:0] P5_CKE [12] = '{4'b1001, 4'b1111, 4'b1101, 4'b1001,
                                         4'b1111, 4'b1101, 4'b1000, 4'b1100,
                                         4'b1110, 4'b1010, 4'b1111, 4'b1101};
  localparam logic [3:0] P5_TCK [12] = '{4'b0001, 4'b0111, 4'b0001, 4'b0000,
                                         4'b1111, 4'b0000, 4'b0000, 4'b0100,
                                         4'b0010, 4'b0000, 4'b0101, 4'b0000};

  logic           clk = 1'b0;
  logic           rst_, ena, sync, cfg_valid, cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]   cfg_period, cfg_high;
  logic [CH-1:0]  cke, tick;

  cke_gen_multi #(
    .CH(CH), .W(W), .DEF_PERIOD(10), .DEF_HIGH(5)
  ) dut (
    .clk(clk), .rst_(rst_), .ena(ena), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high),
    .cke(cke), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            k;
    string         nm;
    logic [CH-1:0] cke;
    logic [CH-1:0] tick;
    logic          rdy;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   k_now = -3;

  logic [CH-1:0] c, t;
  logic          r;
  int            j, cnt;

  task automatic check(input string nm, input int k,
                       input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d: got %b expected %b", nm, k, act, exp);
    end
  endtask

  // Queue this cycle's expectation, then advance one clock. sync and
  // cfg_valid are one-cycle pulses by default.
  task automatic step(input string nm, input logic [CH-1:0] ec,
                      input logic [CH-1:0] et, input logic er);
    exp_t e;
    e.k = k_now; e.nm = nm; e.cke = ec; e.tick = et; e.rdy = er;
    sb.push_back(e);
    @(posedge clk); #1;
    k_now++;
    cfg_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic issue(input logic [CHW-1:0] ch, input cfg_t cf);
    cfg_ch     = ch;
    cfg_period = cf.period;
    cfg_high   = cf.high;
    cfg_valid  = 1'b1;
  endtask

  // Monitor: compares away from the active edge.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        m = sb.pop_front();
        check({m.nm, ".cke"},   m.k, cke,                   m.cke);
        check({m.nm, ".tick"},  m.k, tick,                  m.tick);
        check({m.nm, ".ready"}, m.k, {3'b000, cfg_ready},   {3'b000, m.rdy});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_ = 1'b0; ena = 1'b1; sync = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_period = '0; cfg_high = '0;
    @(posedge clk); #1;

    // In reset: everything gated low, not ready.
    for (int i = 0; i < 3; i++) step("rst", 4'b0000, 4'b0000, 1'b0);
    rst_ = 1'b1;

    // Defaults: 5 high / 5 low, tick every 10.
    for (int k = 0; k < 20; k++) begin
      c = ((k % 10) < 5) ? '1 : '0;
      t = ((k % 10) == 0) ? '1 : '0;
      step("dflt", c, t, 1'b1);
    end

    // ch1 -> period 4 high 1 at count 3; lands after the 10-cycle period.
    for (int k = 20; k < 38; k++) begin
      cfg_ch = 2'd1;
      if (k == 23) issue(2'd1, cfg_t'{26'd4, 26'd1});
      c = ((k % 10) < 5) ? '1 : '0;
      t = ((k % 10) == 0) ? '1 : '0;
      if (k >= 30) begin
        c[1] = ((k - 30) % 4 == 0);
        t[1] = c[1];
      end
      step("reprog", c, t, !(k >= 24 && k < 30));
    end

    // Boundary duties, applied together by sync at k=43.
    for (int k = 38; k < 52; k++) begin
      cfg_ch = 2'd0;
      if (k == 40) issue(2'd2, cfg_t'{26'd4, 26'd0});
      if (k == 41) issue(2'd3, cfg_t'{26'd4, 26'd7});
      if (k == 42) issue(2'd0, cfg_t'{26'd0, 26'd1});
      if (k == 43) sync = 1'b1;
      if (k < 44) begin
        cnt  = (k - 30) % 10;
        c    = {CH{cnt < 5}};
        t    = {CH{cnt == 0}};
        c[1] = ((k - 30) % 4 == 0);
        t[1] = c[1];
        r    = (k != 43);
      end else begin
        j = k - 44;
        c[0] = 1'b1;             t[0] = 1'b1;
        c[1] = (j % 4 == 0);     t[1] = c[1];
        c[2] = 1'b0;             t[2] = (j % 4 == 0);
        c[3] = 1'b1;             t[3] = (j % 4 == 0);
        r    = 1'b1;
      end
      step("duty", c, t, r);
    end

    // ch3 -> period 10 high 8; freeze at ch3 count 6 with a ch2 update
    // accepted while frozen.
    for (int k = 52; k < 70; k++) begin
      ena    = !(k >= 62 && k <= 64);
      cfg_ch = (k < 62) ? 2'd3 : 2'd2;
      if (k == 52) issue(2'd3, cfg_t'{26'd10, 26'd8});
      if (k == 62) issue(2'd2, cfg_t'{26'd3, 26'd2});
      r = !((k >= 53 && k <= 55) || k == 63);
      if (!ena) begin
        c = '0; t = '0;
      end else if (k < 62) begin
        j = (k - 44) % 4;
        c[0] = 1'b1;  t[0] = 1'b1;
        c[1] = (j == 0); t[1] = c[1];
        c[2] = 1'b0;  t[2] = (j == 0);
        c[3] = 1'b1;  t[3] = (k < 56) ? (j == 0) : (k == 56);
      end else begin
        c[0] = 1'b1;  t[0] = 1'b1;
        j = (k - 47) % 4;
        c[1] = (j == 0); t[1] = c[1];
        j = (k - 65) % 3;
        c[2] = (j < 2);  t[2] = (j == 0);
        cnt = (k == 69) ? 0 : k - 59;
        c[3] = (cnt < 8); t[3] = (cnt == 0);
      end
      step("ena", c, t, r);
    end
    ena = 1'b1;

    // sync with ch0 pending and a same-cycle accept on ch1.
    for (int k = 70; k < 82; k++) begin
      cfg_ch = (k < 73) ? 2'd0 : 2'd1;
      if (k == 70) issue(2'd0, cfg_t'{26'd20, 26'd10});
      if (k == 72) issue(2'd0, cfg_t'{26'd6, 26'd2});
      if (k == 73) begin
        issue(2'd1, cfg_t'{26'd5, 26'd3});
        sync = 1'b1;
      end
      r = !(k == 71 || (k >= 74 && k <= 77));
      step("sync", P5_CKE[k-70], P5_TCK[k-70], r);
    end

    // Reset mid-count with ch0 pending: defaults return, update discarded.
    cfg_ch = 2'd0;
    issue(2'd0, cfg_t'{26'd7, 26'd1});
    step("prerst", 4'b0000, 4'b0000, 1'b1);
    rst_ = 1'b0;
    step("midrst", 4'b0000, 4'b0000, 1'b0);
    rst_ = 1'b1;
    for (int k = 84; k < 98; k++) begin
      j = k - 84;
      c = ((j % 10) < 5) ? '1 : '0;
      t = ((j % 10) == 0) ? '1 : '0;
      step("postrst", c, t, 1'b1);
    end

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cke_gen_multi.md
Name: cke_gen_multi

Overview:
- Multi-channel, runtime-programmable clock-enable generator; successor to the single-channel fixed-period half-duty splitter.
- Each of CH channels produces a clock-enable with its own period and high time, plus a one-cycle period-start tick.
- Channels are reprogrammed through a valid/ready config port; updates take effect glitch-free at period boundaries.
- Sits beside the system clock root and feeds cke to peripherals (UART baud, LED/PWM, timers) in the utils sector.

Parameters:
- CH, 4, number of independent channels (>=1).
- W, 26, width of period/high/count fields; must satisfy 2**W > DEF_PERIOD.
- DEF_PERIOD, 50000000, reset period in clk cycles for every channel.
- DEF_HIGH, 25000000, reset high time in clk cycles for every channel.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_  in  1  reset, synchronous, active-low.
- ena  in  1  global enable; low freezes all counters and forces cke/tick to 0.
- sync  in  1  one-cycle pulse: restart all channels at count 0 on next edge.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  config request accepted when valid && ready.
- cfg_ch  in  max(1,$clog2(CH))  target channel index.
- cfg_period  in  W  new period in cycles.
- cfg_high  in  W  new high time in cycles.
- cke  out  CH  per-channel clock enable.
- tick  out  CH  per-channel period-start pulse.

Behaviour:
- Per channel state: count[W], period[W], high[W], pend (1b), pend_period[W], pend_high[W].
- Reset (rst_=0 at edge): count=0, period=DEF_PERIOD, high=DEF_HIGH, pend=0. While rst_=0: cke=0, tick=0, cfg_ready=0.
- Period clamp: stored period of 0 behaves as 1. Comparisons are unsigned, W bits. No arithmetic overflow; count never exceeds period-1.
- Counting: when ena=1, count advances each cycle and wraps from eff_period-1 to 0. When ena=0, count holds.
- Outputs are combinational from registered state, gated by rst_ and ena; no extra latency.
  - cke[i] = ena && (count < high). high=0 gives constant 0; high>=period gives constant 1.
  - tick[i] = ena && (count == 0).
- Config handshake:
  - cfg_ready = rst_ && !pend[cfg_ch].
  - On accept, pend_* are loaded and pend is set. At most one pending update per channel; further requests stall.
  - cfg_ch >= CH: cfg_ready=1 and the request is accepted and dropped.
- Apply rule: pending values move into period/high, pend clears, and count goes to 0 in any of these cases:
  - (a) ena=1 and count==eff_period-1 (the wrap cycle);
  - (b) ena=0, applied at the next edge;
  - (c) sync=1.
  - The new period therefore starts cleanly with tick.
- sync=1: every count goes to 0 at the edge, and any pend present before this edge is applied. A request accepted in the same cycle lands in pend and waits for the next wrap.
- Accept in the apply cycle of the same channel: impossible, since cfg_ready=0 while pend=1.
- Reset mid-operation discards pending updates and restores the defaults.

Decomposition:
- Package cke_gen_pkg holds:
  - constants DEF_PERIOD and DEF_HIGH;
  - typedef cfg_t {period, high} parametrised by W (or a localparam width plus a packed struct);
  - the clamp helper function.
- Sub-module cke_chan holds one channel's count/period/high/pend registers and its outputs. The top module instantiates CH copies via generate and does cfg_ch decode plus cfg_ready mux.

Test Plan:
- Reset defaults: scale DEF_PERIOD=10, DEF_HIGH=5. Release rst_ with ena=1 -> cke high cycles 0-4, low 5-9, repeating; tick on cycles 0, 10, 20.
- Reprogram ch1 to period=4, high=1 mid-period -> cfg_ready drops for ch1. Old 10-cycle pattern completes, then tick plus cke 1,0,0,0 repeating. cfg_ready returns the cycle after apply.
- Boundary duties: ch2 high=0 -> cke stays 0. ch3 high=7 with period=4 -> cke stays 1. period=0 -> behaves as period 1: tick and cke=1 (if high>=1) every cycle.
- ena low for 3 cycles at count=6 -> cke/tick 0 and count frozen. On restore, count resumes at 6. A pending update during ena=0 applies at the next edge.
- sync with pending on ch0 plus a new accept on ch1 in the same cycle -> all counts 0 next cycle, ch0 applies new values immediately, ch1 stays pending until its next wrap.
- Assert rst_ low for one cycle mid-count with pend set -> next cycle all defaults, pend clear, cfg_ready=1 once rst_ is high.
